// File: rtl/uff_pkg.sv
// Shared definitions for the universal flip-flop bank: per-bit mode encodings.
package uff_pkg;

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_JK = 2'b10,
    MODE_SR = 2'b11
  } uff_mode_t;

endpackage : uff_pkg

// File: rtl/uff_cell.sv
// Next-state logic for one bit of the flip-flop bank; purely combinational.
module uff_cell
  import uff_pkg::*;
(
  input  logic      q,
  input  logic      a,
  input  logic      b,
  input  uff_mode_t mode,
  output logic      q_next,
  output logic      illegal_bit
);

  always_comb begin
    // NOTE: default first so every path assigns q_next and no latch is inferred.
    q_next = q;
    unique case (mode)
      MODE_D:  q_next = a;
      MODE_T:  q_next = q ^ a;
      MODE_JK: begin
        unique case ({a, b})
          2'b00:   q_next = q;
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          default: q_next = ~q;
        endcase
      end
      MODE_SR: begin
        // S=R=1 holds the bit; the bank flags the event separately.
        unique case ({a, b})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          default: q_next = q;
        endcase
      end
      default: q_next = q;
    endcase
  end

  assign illegal_bit = (mode == MODE_SR) && a && b;

endmodule : uff_cell

// File: rtl/universal_ff_bank.sv
// Bank of WIDTH independent D/T/JK/SR flip-flops with SR-illegal detection.
// Define UFF_ERR_CNT_EN to add the saturating err_cnt port and counter.
module universal_ff_bank
  import uff_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int              CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq,
  output logic             illegal,
`ifdef UFF_ERR_CNT_EN
  output logic             illegal_sticky,
  output logic [CNT_W-1:0] err_cnt
`else
  output logic             illegal_sticky
`endif
);

  uff_mode_t        mode_t;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] illegal_bits;
  logic             illegal_evt;

  assign mode_t = uff_mode_t'(mode);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    uff_cell u_cell (
      .q           (q[i]),
      .a           (a[i]),
      .b           (b[i]),
      .mode        (mode_t),
      .q_next      (q_next[i]),
      .illegal_bit (illegal_bits[i])
    );
  end

  // Several offending bits on one edge are a single event.
  assign illegal_evt = en && (|illegal_bits);

  // Complement is combinational so q and nq can never disagree, even in reset.
  assign nq = ~q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking assignments for all registered state.
      q              <= RESET_VAL;
      illegal        <= 1'b0;
      illegal_sticky <= 1'b0;
    end else begin
      if (en) q <= q_next;
      illegal <= illegal_evt;
      if (illegal_evt)  illegal_sticky <= 1'b1;
      else if (clr_err) illegal_sticky <= 1'b0;
    end
  end

`ifdef UFF_ERR_CNT_EN
  // A new event beats a simultaneous clear, restarting the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (illegal_evt) begin
      if (clr_err)             err_cnt <= CNT_W'(1);
      else if (err_cnt != '1)  err_cnt <= err_cnt + CNT_W'(1);
    end else if (clr_err) begin
      err_cnt <= '0;
    end
  end
`endif

endmodule : universal_ff_bank

// File: tb/tb_universal_ff_bank.sv
// Directed self-checking bench for universal_ff_bank (WIDTH=8, RESET_VAL=0, CNT_W=4).
module tb_universal_ff_bank;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] nq;
  logic             illegal;
  logic             illegal_sticky;
`ifdef UFF_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  universal_ff_bank #(
    .WIDTH     (WIDTH),
    .RESET_VAL ({WIDTH{1'b0}}),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .mode           (mode),
    .a              (a),
    .b              (b),
    .clr_err        (clr_err),
    .q              (q),
    .nq             (nq),
    .illegal        (illegal),
`ifdef UFF_ERR_CNT_EN
    .illegal_sticky (illegal_sticky),
    .err_cnt        (err_cnt)
`else
    .illegal_sticky (illegal_sticky)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input logic [CNT_W-1:0] exp);
`ifdef UFF_ERR_CNT_EN
    check(tag, 32'(err_cnt), 32'(exp));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset pulse between edges: values must appear without a clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_q", 32'(q), 32'h00);
    check("rst_nq", 32'(nq), 32'hFF);
    check("rst_illegal", 32'(illegal), 32'h0);
    check("rst_sticky", 32'(illegal_sticky), 32'h0);
    check_cnt("rst_cnt", 4'h0);
    #4 rst = 1'b0;

    // D then T then hold.
    en = 1'b1; mode = 2'b00; a = 8'hA5; b = 8'h00;
    step();
    check("d_q", 32'(q), 32'hA5);
    check("d_nq", 32'(nq), 32'h5A);
    mode = 2'b01; a = 8'h0F;
    step();
    check("t_q", 32'(q), 32'hAA);
    en = 1'b0; a = 8'hFF;
    step();
    check("hold_q", 32'(q), 32'hAA);

    // JK: a=F0 b=3C on q=AA -> set 7:6, toggle 5:4, reset 3:2, hold 1:0.
    en = 1'b1; mode = 2'b10; a = 8'hF0; b = 8'h3C;
    step();
    check("jk_q", 32'(q), 32'hD2);
    check("jk_no_illegal", 32'(illegal), 32'h0);

    // SR: clear via R, then S/R with one illegal bit.
    mode = 2'b11; a = 8'h00; b = 8'hFF;
    step();
    check("sr_reset_q", 32'(q), 32'h00);
    a = 8'h81; b = 8'h01;
    step();
    check("sr_q", 32'(q), 32'h80);
    check("sr_illegal", 32'(illegal), 32'h1);
    check("sr_sticky", 32'(illegal_sticky), 32'h1);
    check_cnt("sr_cnt", 4'h1);
    mode = 2'b00; a = 8'h80; b = 8'h00;
    step();
    check("ill_pulse_end", 32'(illegal), 32'h0);
    check("sticky_holds", 32'(illegal_sticky), 32'h1);

    // Disabled SR conflict is not an event.
    en = 1'b0; mode = 2'b11; a = 8'hFF; b = 8'hFF;
    step();
    check("en0_illegal", 32'(illegal), 32'h0);
    check("en0_q", 32'(q), 32'h80);
    check_cnt("en0_cnt", 4'h1);

    // Saturation over 20 illegal edges.
    en = 1'b1; a = 8'h01; b = 8'h01;
    for (int i = 0; i < 20; i++) step();
    check("sat_illegal", 32'(illegal), 32'h1);
    check_cnt("sat_cnt", 4'hF);
    step();
    check_cnt("sat_hold", 4'hF);
    clr_err = 1'b1;
    step();
    check("clr_evt_sticky", 32'(illegal_sticky), 32'h1);
    check_cnt("clr_evt_cnt", 4'h1);
    en = 1'b0;
    step();
    check("clr_en0_sticky", 32'(illegal_sticky), 32'h0);
    check("clr_en0_illegal", 32'(illegal), 32'h0);
    check_cnt("clr_en0_cnt", 4'h0);
    clr_err = 1'b0;

    // Reset mid-run while toggling.
    en = 1'b1; mode = 2'b01; a = 8'hFF; b = 8'h00;
    step();
    check("tog_q", 32'(q), 32'h7F);
    #3 rst = 1'b1;
    #1;
    check("midrst_q", 32'(q), 32'h00);
    check("midrst_nq", 32'(nq), 32'hFF);
    step();
    check("rst_held_q", 32'(q), 32'h00);
    #3 rst = 1'b0;
    step();
    check("post_rst_q", 32'(q), 32'hFF);
    check("post_rst_nq", 32'(nq), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_universal_ff_bank
